burt_h_window_gen_uint12: RTL
=============================

Name: burt_h_window_gen_uint12

Overview:
Horizontal 1x5 window generator that feeds the horizontal Burt (1,4,6,4,1) filter stage. It takes a raster stream of uint12 pixels tagged with col/row/valid and emits one 5-tap window per input column. Each window is centred on its output col_o, and line edges are handled by pixel replication. It sits between the row source (sensor or line buffer) and the custom_burt_h filter, whose window/col/row/valid inputs it drives directly.

Parameters:
IMAGE_WIDTH, 640, pixels per line; elaboration fails unless >= 5.

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
data_i  input  12  pixel value.
col_i  input  16  pixel column, 0..IMAGE_WIDTH-1.
row_i  input  16  pixel row.
valid_i  input  1  pixel qualifier; there is no backpressure.
window_o  output  [11:0] x [1][5]  window; [0][0] = col c-2 ... [0][4] = col c+2.
col_o  output  16  centre column c of window_o.
row_o  output  16  row of the line being emitted.
valid_o  output  1  window qualifier.
error_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): valid_o=0, error_o=0, window_o all 0, col_o=0, row_o=0, FSM=IDLE. Reset mid-line abandons the line silently.
- Notation: p(k) is the pixel of column k on the current line. Replicated window: w[i] = p(clamp(c-2+i, 0, IMAGE_WIDTH-1)).
- All outputs are registered. Output fields other than valid_o hold their last value while valid_o=0.
- FSM states: IDLE, FILL, STREAM, FLUSH1, FLUSH2.
- IDLE:
  - valid col_i==0: store p0, latch row_i, expected col=1, go to FILL.
  - valid col_i!=0: drop the pixel, set error_o, stay in IDLE.
- FILL (accepting col 1):
  - Store p1, go to STREAM. No output.
- STREAM, accepting col k (2..W-1):
  - The cycle after acceptance, emit the window centred at c=k-2.
  - So col 0 output follows p2, col 1 follows p3, and so on.
  - After accepting k=W-1, go to FLUSH1.
- FLUSH1: emit centre c=W-2 = {p(W-4), p(W-3), p(W-2), p(W-1), p(W-1)}, then go to FLUSH2.
- FLUSH2: emit centre c=W-1 = {p(W-3), p(W-2), p(W-1), p(W-1), p(W-1)}, then go to IDLE.
- Latency:
  - In-line windows appear 1 cycle after the pixel two columns to the right is accepted.
  - With p(W-1) accepted at cycle t, windows for c=W-3, W-2, W-1 appear at t+1, t+2, t+3 on consecutive cycles.
  - Exactly IMAGE_WIDTH windows are emitted per complete line.
- Horizontal blanking: upstream guarantees at least 2 invalid cycles after col W-1.
  - valid_i during FLUSH1/FLUSH2: the pixel is dropped, error_o is set, and the flush completes unchanged.
- Column discipline in FILL/STREAM, for any valid pixel:
  - col_i == expected: accept.
  - col_i==0 and col_i != expected: abandon the partial line with no flush windows, set error_o, restart as if in IDLE (store p0, go to FILL).
  - Any other col_i: drop the pixel, set error_o, keep state and expected col.
- valid_i gaps inside a line are legal: the state is held and no window is emitted during the gap.
- error_o is cleared only by rst_i.
- Pixel values pass through unmodified: no arithmetic on data, only selection and replication.

Test Plan:
IMAGE_WIDTH=8 throughout; p(k) = 100+k.
1. One line, row_i=3, pixels back-to-back, then idle -> 8 windows on consecutive cycles starting 1 cycle after p2.
   - c=0 is {100,100,100,101,102}.
   - c=3 is {101,102,103,104,105}.
   - c=7 is {105,106,107,107,107}.
   - row_o=3 throughout; error_o=0.
2. Same line with 1-3 cycle valid_i gaps after cols 1, 4 and 7 -> identical window values and col_o sequence.
   - valid_o low only during the gaps.
   - The final two windows follow p7 at +2 and +3 cycles.
3. Two lines with exactly 2 blanking cycles between them -> 16 windows, with row_o switching at c=0 of line 2 and error_o=0.
   - Repeat with 1 blanking cycle -> the line-2 col 0 pixel is dropped, error_o=1, line 1 is still complete, and line 2 emits nothing.
4. Pixel with col_i=5 presented in IDLE -> no output and error_o=1.
   - In STREAM after col 3, a col_i=6 pixel -> dropped, error_o=1; then cols 4..7 -> correct windows c=2..7.
5. col_i=0 arriving after col 4 of a line -> no flush windows for the old line, error_o=1, and the new line's c=0 window is emitted correctly.
6. rst_i asserted asynchronously mid-STREAM -> valid_o, col_o, row_o, window_o and error_o all read 0 immediately, before the next edge.
   - After release, a fresh line produces the full correct 8 windows.

Source files
------------

// File: rtl/burt_h_window_gen_uint12_if.sv
// Raster-in / window-out bundle between a row source and the horizontal Burt filter stage.
// The master drives the pixel stream; the slave (window generator) drives the window side.
interface burt_h_window_gen_uint12_if;
  logic [11:0]             data_i;
  logic [15:0]             col_i;
  logic [15:0]             row_i;
  logic                    valid_i;
  logic [0:0][0:4][11:0]   window_o;
  logic [15:0]             col_o;
  logic [15:0]             row_o;
  logic                    valid_o;
  logic                    error_o;

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  window_o, col_o, row_o, valid_o, error_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output window_o, col_o, row_o, valid_o, error_o
  );
endinterface

// File: rtl/burt_h_window_gen_uint12.sv
// Horizontal 1x5 window generator with edge replication, one window per input column.
// A five-deep tap line holds the newest pixels; the flush states re-shift the last pixel.
module burt_h_window_gen_uint12 #(
  parameter int IMAGE_WIDTH = 640
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  burt_h_window_gen_uint12_if.slave    bus
);
  localparam int          DATA_W   = 12;
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] PEN_COL  = 16'(IMAGE_WIDTH - 2);

  if (IMAGE_WIDTH < 5) begin : g_width_check
    $error("IMAGE_WIDTH must be at least 5");
  end

  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH1, FLUSH2} state_t;

  state_t                        state_q, state_d;
  // taps[0] is the newest pixel, taps[4] the oldest
  logic [4:0][DATA_W-1:0]        taps_q, taps_d, shifted;
  logic [15:0]                   exp_col_q, exp_col_d;
  logic [15:0]                   line_row_q, line_row_d;
  logic [0:0][0:4][DATA_W-1:0]   window_q, window_d;
  logic [15:0]                   col_q, col_d;
  logic [15:0]                   row_q, row_d;
  logic                          valid_q, valid_d;
  logic                          error_q, error_d;

  function automatic logic [0:0][0:4][DATA_W-1:0] to_window(input logic [4:0][DATA_W-1:0] t);
    logic [0:0][0:4][DATA_W-1:0] w;
    for (int i = 0; i < 5; i++) w[0][i] = t[4-i];
    return w;
  endfunction

  always_comb begin
    state_d    = state_q;
    taps_d     = taps_q;
    shifted    = {taps_q[3:0], bus.data_i};
    exp_col_d  = exp_col_q;
    line_row_d = line_row_q;
    window_d   = window_q;
    col_d      = col_q;
    row_d      = row_q;
    valid_d    = 1'b0;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.col_i == 16'd0) begin
            taps_d     = {5{bus.data_i}};
            line_row_d = bus.row_i;
            exp_col_d  = 16'd1;
            state_d    = FILL;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      FILL, STREAM: begin
        if (bus.valid_i) begin
          if (bus.col_i == exp_col_q) begin
            taps_d    = shifted;
            exp_col_d = exp_col_q + 16'd1;
            if (state_q == FILL) begin
              state_d = STREAM;
            end else begin
              valid_d  = 1'b1;
              window_d = to_window(shifted);
              col_d    = exp_col_q - 16'd2;
              row_d    = line_row_q;
              if (exp_col_q == LAST_COL) state_d = FLUSH1;
            end
          end else if (bus.col_i == 16'd0) begin
            // A new line start abandons the partial line without flushing it
            error_d    = 1'b1;
            taps_d     = {5{bus.data_i}};
            line_row_d = bus.row_i;
            exp_col_d  = 16'd1;
            state_d    = FILL;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      FLUSH1, FLUSH2: begin
        shifted  = {taps_q[3:0], taps_q[0]};
        taps_d   = shifted;
        valid_d  = 1'b1;
        window_d = to_window(shifted);
        row_d    = line_row_q;
        col_d    = (state_q == FLUSH1) ? PEN_COL : LAST_COL;
        state_d  = (state_q == FLUSH1) ? FLUSH2 : IDLE;
        if (bus.valid_i) error_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      taps_q     <= '0;
      exp_col_q  <= '0;
      line_row_q <= '0;
      window_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      taps_q     <= taps_d;
      exp_col_q  <= exp_col_d;
      line_row_q <= line_row_d;
      window_q   <= window_d;
      col_q      <= col_d;
      row_q      <= row_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign bus.window_o = window_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;
  assign bus.valid_o  = valid_q;
  assign bus.error_o  = error_q;
endmodule
